// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N requesters.
// The grant is held for a whole multi-byte message, with an idle-lock timeout.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int IW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*8-1:0]  req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic            tx_send_req,
  output logic [7:0]      tx_data,
  input  logic            tx_busy,
  output logic [IW-1:0]   grant_id,
  output logic            locked,
  output logic            lock_abort
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic          seen_busy;
  logic [31:0]   idle_cnt;

  logic          arb_phase;
  logic          owner_valid;
  logic          grant_valid;
  logic [IW-1:0] winner;
  logic [7:0]    win_data;
  logic          idle_count_en;
  logic          abort_now;
  int            cand;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (int'(idx) == N - 1) return '0;
    return idx + IW'(1);
  endfunction

  // WAIT with busy already observed and now low behaves as ARB, so the next
  // byte can be accepted in the very cycle the transmitter goes idle.
  always_comb begin
    arb_phase     = (state == ST_ARB) ||
                    ((state == ST_WAIT) && seen_busy && !tx_busy);
    owner_valid   = req_valid[grant_id];
    grant_valid   = 1'b0;
    winner        = '0;
    cand          = 0;
    if (arb_phase && !tx_busy) begin
      if (locked) begin
        grant_valid = owner_valid;
        winner      = grant_id;
      end else begin
        // Descending scan so the candidate closest to ptr is assigned last.
        for (int k = N - 1; k >= 0; k--) begin
          cand = (int'(ptr) + k) % N;
          if (req_valid[cand]) begin
            grant_valid = 1'b1;
            winner      = IW'(cand);
          end
        end
      end
    end
    idle_count_en = arb_phase && locked && !owner_valid;
    abort_now     = idle_count_en && (idle_cnt == 32'(LOCK_TIMEOUT - 1));
    win_data      = req_data[int'(winner) * 8 +: 8];
    req_ready     = '0;
    if (reset_n && grant_valid) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_ARB;
      ptr         <= '0;
      seen_busy   <= 1'b0;
      idle_cnt    <= '0;
      locked      <= 1'b0;
      tx_send_req <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      lock_abort  <= 1'b0;
    end else begin
      tx_send_req <= 1'b0;
      lock_abort  <= 1'b0;
      if (grant_valid) begin
        tx_data     <= win_data;
        grant_id    <= winner;
        tx_send_req <= 1'b1;
        locked      <= !req_last[winner];
        if (req_last[winner]) ptr <= next_idx(winner);
        idle_cnt    <= '0;
        state       <= ST_ISSUE;
      end else if (abort_now) begin
        locked     <= 1'b0;
        ptr        <= next_idx(grant_id);
        lock_abort <= 1'b1;
        idle_cnt   <= '0;
        state      <= ST_ARB;
      end else begin
        if (!locked) idle_cnt <= '0;
        else if (idle_count_en) idle_cnt <= idle_cnt + 32'd1;
        case (state)
          ST_ISSUE: begin
            state     <= ST_WAIT;
            seen_busy <= 1'b0;
          end
          ST_WAIT: begin
            if (!seen_busy) begin
              if (tx_busy) seen_busy <= 1'b1;
            end else if (!tx_busy) begin
              state <= ST_ARB;
            end
          end
          default: state <= ST_ARB;
        endcase
      end
    end
  end

endmodule
